// File: rtl/bcd_mul_if.sv
// Request/result bundle between a bus front end and the BCD multiplier.
//   start   : request to begin an operation (sampled only while idle)
//   a_bcd   : multi-digit BCD operand, digit 0 in bits [3:0]
//   b_digit : single BCD multiplier digit
//   busy    : operation in progress
//   done    : one-cycle completion pulse
//   err     : an accepted operand held a non-BCD digit
//   product : BCD result, DIGITS+1 digits, top digit is the final carry
// Modports: master drives the request, slave (the multiplier) drives the result.
interface bcd_mul_if #(
   parameter int unsigned DIGITS = 4
) ();
   logic                    start;
   logic [4*DIGITS-1:0]     a_bcd;
   logic [3:0]              b_digit;
   logic                    busy;
   logic                    done;
   logic                    err;
   logic [4*(DIGITS+1)-1:0] product;

   modport master (
      output start, a_bcd, b_digit,
      input  busy, done, err, product
   );

   modport slave (
      input  start, a_bcd, b_digit,
      output busy, done, err, product
   );
endinterface

// File: rtl/bcd_mul_seq.sv
// Sequential multi-digit BCD x single-digit BCD multiplier.
// One shared digit multiplier (mul4x4s) is stepped across the operand digits,
// least significant first, with decimal correction and carry applied each cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset; abandons any operation in flight
//   bus   : bcd_mul_if slave (start/a_bcd/b_digit in, busy/done/err/product out)
// Parameters:
//   DIGITS : number of BCD digits in operand A (>= 1)
// Build option:
//   BCD_MUL_ZSKIP_EN : when defined, an all-zero A or a zero B skips the digit
//                      loop and completes one cycle after accept. The result is
//                      the same either way; only latency differs.

// Combinational digit multiplier. Non-BCD inputs yield zero; the controller
// checks digit validity itself and does not rely on this.
module mul4x4s (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [6:0] p
);
   always_comb begin
      p = '0;
      if (a <= 4'd9 && b <= 4'd9) begin
         p = {3'b000, a} * {3'b000, b};
      end
   end
endmodule

module bcd_mul_seq #(
   parameter int unsigned DIGITS = 4
) (
   input  logic    clk,
   input  logic    reset,
   bcd_mul_if.slave bus
);
   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned AW   = 4 * DIGITS;
   localparam int unsigned PW   = 4 * (DIGITS + 1);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   a_q, a_d;
   logic [3:0]      b_q, b_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [3:0]      carry_q, carry_d;
   logic [PW-1:0]   product_q, product_d;
   logic            err_q, err_d;

   logic [3:0] a_digit;
   logic [6:0] m;
   logic [6:0] p;
   logic [3:0] tens;
   logic [3:0] units;
   logic       bad;
`ifdef BCD_MUL_ZSKIP_EN
   logic       zero_work;
`endif

   // Multiplier inputs come from registered state only.
   assign a_digit = a_q[{idx_q, 2'b00} +: 4];

   mul4x4s u_mul (
      .a (a_digit),
      .b (b_q),
      .p (m)
   );

   // p <= 81 + 8 = 89, so the tens digit is found by comparing against the
   // multiples of ten and the units by a constant multiply-subtract.
   always_comb begin
      p    = m + {3'b000, carry_q};
      tens = '0;
      for (int k = 1; k <= 8; k++) begin
         if (p >= 7'(10 * k)) tens = 4'(k);
      end
      units = 4'(p - ({3'b000, tens} * 7'd10));
   end

   // Operand validity, evaluated on the live inputs at accept time.
   always_comb begin
      bad = (bus.b_digit > 4'd9);
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bus.a_bcd[4*i +: 4] > 4'd9) bad = 1'b1;
      end
   end

`ifdef BCD_MUL_ZSKIP_EN
   assign zero_work = (bus.b_digit == 4'd0) || (bus.a_bcd == '0);
`endif

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      product_d = product_q;
      err_d     = err_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_d       = bus.a_bcd;
               b_d       = bus.b_digit;
               idx_d     = '0;
               carry_d   = '0;
               product_d = '0;
               err_d     = bad;
               state_d   = bad ? StFin : StRun;
`ifdef BCD_MUL_ZSKIP_EN
               if (!bad && zero_work) state_d = StFin;
`endif
            end
         end
         StRun: begin
            product_d[{idx_q, 2'b00} +: 4] = units;
            carry_d = tens;
            if (idx_q == IdxW'(DIGITS - 1)) begin
               product_d[4*DIGITS +: 4] = tens;
               idx_d   = '0;
               state_d = StFin;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= '0;
         carry_q   <= '0;
         product_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         product_q <= product_d;
         err_q     <= err_d;
      end
   end

   assign bus.busy    = (state_q != StIdle);
   assign bus.done    = (state_q == StFin);
   assign bus.err     = err_q;
   assign bus.product = product_q;
endmodule
